// File: rtl/psr_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : psr_cond_unit
// Description : Processor status register and branch condition evaluator.
//               Captures ALU flags {C,F,Z,L,N} under a per-bit select mask,
//               feeds the carry back to the ALU, resolves condition codes
//               into a registered taken/not-taken result, and keeps a small
//               LIFO shadow stack of the PSR for interrupt entry/return.
// Build option: FLAG_BYPASS_EN - when defined, a condition request sees the
//               PSR value being written in the same cycle (no bubble after
//               a flag-setting instruction). When undefined, it sees the
//               registered PSR.
// Ports       :
//   clk          in   1  system clock, rising edge
//   reset        in   1  asynchronous active-high reset
//   stall        in   1  freeze all state; br_valid forced low
//   flags_in     in   5  ALU flags {C,F,Z,L,N}
//   flags_sel    in   5  per-bit flag update mask
//   flags_en     in   1  flag update enable
//   psr_wr       in   1  explicit PSR write
//   psr_wdata    in   5  explicit PSR write data
//   irq_save     in   1  push PSR onto shadow stack
//   rti_restore  in   1  pop shadow stack into PSR
//   cond_req     in   1  condition evaluation request
//   cond_code    in   4  condition code
//   psr          out  5  current PSR
//   psr_c        out  1  carry bit of PSR, to the ALU
//   br_valid     out  1  result strobe, one cycle after an accepted request
//   br_taken     out  1  condition result
//   stk_depth    out  3  shadow stack occupancy
//   stk_ovf      out  1  sticky: push while full
//   stk_unf      out  1  sticky: pop while empty
// Revision    : 1.0 - initial release
// ============================================================================
module psr_cond_unit #(
    parameter logic [4:0] RESET_PSR    = 5'b00000,
    parameter int         SHADOW_DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic [4:0] flags_in,
    input  logic [4:0] flags_sel,
    input  logic       flags_en,
    input  logic       psr_wr,
    input  logic [4:0] psr_wdata,
    input  logic       irq_save,
    input  logic       rti_restore,
    input  logic       cond_req,
    input  logic [3:0] cond_code,
    output logic [4:0] psr,
    output logic       psr_c,
    output logic       br_valid,
    output logic       br_taken,
    output logic [2:0] stk_depth,
    output logic       stk_ovf,
    output logic       stk_unf
);

    localparam logic [2:0] c_depth_max = 3'(SHADOW_DEPTH);

    logic [4:0] r_psr;
    logic       r_br_valid;
    logic       r_br_taken;
    logic [2:0] r_depth;
    logic       r_ovf;
    logic       r_unf;
    logic [4:0] r_stk [0:SHADOW_DEPTH-1];

    logic       w_pop_ok;
    logic       w_pop_err;
    logic       w_push_req;
    logic       w_push_ok;
    logic       w_push_err;
    logic [4:0] w_stk_top;
    logic [4:0] w_psr_next;
    logic [4:0] w_eval_psr;
    logic       w_cond_result;

    // Condition evaluation over a PSR value ordered {C,F,Z,L,N}.
    function automatic logic f_eval(input logic [4:0] p, input logic [3:0] code);
        logic c, f, z, l, n;
        c = p[4];
        f = p[3];
        z = p[2];
        l = p[1];
        n = p[0];
        case (code)
            4'd0:    f_eval = z;
            4'd1:    f_eval = !z;
            4'd2:    f_eval = c;
            4'd3:    f_eval = !c;
            4'd4:    f_eval = l;
            4'd5:    f_eval = !l;
            4'd6:    f_eval = n;
            4'd7:    f_eval = !n;
            4'd8:    f_eval = f;
            4'd9:    f_eval = !f;
            4'd10:   f_eval = !l && !z;
            4'd11:   f_eval = l || z;
            4'd12:   f_eval = !n && !z;
            4'd13:   f_eval = n || z;
            4'd14:   f_eval = 1'b1;
            default: f_eval = 1'b0;
        endcase
    endfunction

    // A simultaneous restore takes the stack; the save is silently dropped.
    always_comb begin
        w_pop_ok   = rti_restore && (r_depth != 3'd0);
        w_pop_err  = rti_restore && (r_depth == 3'd0);
        w_push_req = irq_save && !rti_restore;
        w_push_ok  = w_push_req && (r_depth < c_depth_max);
        w_push_err = w_push_req && (r_depth >= c_depth_max);
    end

    // Entry (depth-1) is the top of stack.
    always_comb begin
        w_stk_top = 5'b00000;
        for (int i = 0; i < SHADOW_DEPTH; i++) begin
            if (r_depth == 3'(i + 1)) begin
                w_stk_top = r_stk[i];
            end
        end
    end

    always_comb begin
        w_psr_next = r_psr;
        if (w_pop_ok) begin
            w_psr_next = w_stk_top;
        end else if (psr_wr) begin
            w_psr_next = psr_wdata;
        end else if (flags_en) begin
            w_psr_next = (r_psr & ~flags_sel) | (flags_in & flags_sel);
        end
    end

`ifdef FLAG_BYPASS_EN
    assign w_eval_psr = w_psr_next;
`else
    assign w_eval_psr = r_psr;
`endif

    assign w_cond_result = f_eval(w_eval_psr, cond_code);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_psr      <= RESET_PSR;
            r_br_valid <= 1'b0;
            r_br_taken <= 1'b0;
            r_depth    <= 3'd0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            for (int i = 0; i < SHADOW_DEPTH; i++) begin
                r_stk[i] <= 5'b00000;
            end
        end else if (stall) begin
            r_br_valid <= 1'b0;
        end else begin
            r_psr      <= w_psr_next;
            r_br_valid <= cond_req;
            if (cond_req) begin
                r_br_taken <= w_cond_result;
            end
            // Push stores the registered PSR, not the value updated this cycle.
            for (int i = 0; i < SHADOW_DEPTH; i++) begin
                if (w_push_ok && (r_depth == 3'(i))) begin
                    r_stk[i] <= r_psr;
                end
            end
            if (w_pop_ok) begin
                r_depth <= r_depth - 3'd1;
            end else if (w_push_ok) begin
                r_depth <= r_depth + 3'd1;
            end
            if (w_push_err) begin
                r_ovf <= 1'b1;
            end
            if (w_pop_err) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign psr       = r_psr;
    assign psr_c     = r_psr[4];
    assign br_valid  = r_br_valid;
    assign br_taken  = r_br_taken;
    assign stk_depth = r_depth;
    assign stk_ovf   = r_ovf;
    assign stk_unf   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_psr_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_psr_cond_unit
// Description : Directed self-checking bench for psr_cond_unit, built with
//               RESET_PSR=5'b10100 and SHADOW_DEPTH=2. Expectations for the
//               same-cycle flag/branch case follow FLAG_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psr_cond_unit;

    logic       clk;
    logic       reset;
    logic       stall;
    logic [4:0] flags_in;
    logic [4:0] flags_sel;
    logic       flags_en;
    logic       psr_wr;
    logic [4:0] psr_wdata;
    logic       irq_save;
    logic       rti_restore;
    logic       cond_req;
    logic [3:0] cond_code;
    logic [4:0] psr;
    logic       psr_c;
    logic       br_valid;
    logic       br_taken;
    logic [2:0] stk_depth;
    logic       stk_ovf;
    logic       stk_unf;

    int n_vec;
    int n_miss;

    psr_cond_unit #(
        .RESET_PSR    (5'b10100),
        .SHADOW_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flags_in    (flags_in),
        .flags_sel   (flags_sel),
        .flags_en    (flags_en),
        .psr_wr      (psr_wr),
        .psr_wdata   (psr_wdata),
        .irq_save    (irq_save),
        .rti_restore (rti_restore),
        .cond_req    (cond_req),
        .cond_code   (cond_code),
        .psr         (psr),
        .psr_c       (psr_c),
        .br_valid    (br_valid),
        .br_taken    (br_taken),
        .stk_depth   (stk_depth),
        .stk_ovf     (stk_ovf),
        .stk_unf     (stk_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall       = 1'b0;
        flags_in    = 5'b00000;
        flags_sel   = 5'b00000;
        flags_en    = 1'b0;
        psr_wr      = 1'b0;
        psr_wdata   = 5'b00000;
        irq_save    = 1'b0;
        rti_restore = 1'b0;
        cond_req    = 1'b0;
        cond_code   = 4'd0;
    endtask

    task automatic write_psr(input logic [4:0] v);
        idle_inputs();
        psr_wr    = 1'b1;
        psr_wdata = v;
        step();
        idle_inputs();
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        idle_inputs();
        reset = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_psr",   8'(psr), 8'h14);
        chk("rst_psr_c", 8'(psr_c), 8'h1);
        chk("rst_depth", 8'(stk_depth), 8'h0);
        chk("rst_valid", 8'(br_valid), 8'h0);
        chk("rst_taken", 8'(br_taken), 8'h0);
        chk("rst_ovf",   8'(stk_ovf), 8'h0);
        chk("rst_unf",   8'(stk_unf), 8'h0);
        reset = 1'b0;
        step();
        chk("post_rst_psr", 8'(psr), 8'h14);

        // EQ on psr=10100 (Z=1)
        cond_req  = 1'b1;
        cond_code = 4'd0;
        step();
        chk("eq_valid", 8'(br_valid), 8'h1);
        chk("eq_taken", 8'(br_taken), 8'h1);
        cond_req = 1'b0;
        step();
        chk("idle_valid", 8'(br_valid), 8'h0);
        chk("idle_taken_hold", 8'(br_taken), 8'h1);

        // Masked flag update, then write-beats-flags
        write_psr(5'b00000);
        chk("wr_zero", 8'(psr), 8'h00);
        flags_en  = 1'b1;
        flags_sel = 5'b00101;
        flags_in  = 5'b11111;
        step();
        chk("flag_mask", 8'(psr), 8'h05);
        write_psr(5'b00000);
        flags_en  = 1'b1;
        flags_sel = 5'b00101;
        flags_in  = 5'b11111;
        psr_wr    = 1'b1;
        psr_wdata = 5'b10000;
        step();
        idle_inputs();
        chk("wr_beats_flags", 8'(psr), 8'h10);
        chk("psr_c_follow", 8'(psr_c), 8'h1);

        // Shadow stack LIFO and underflow
        write_psr(5'b00100);
        irq_save = 1'b1;
        step();
        idle_inputs();
        chk("push1_depth", 8'(stk_depth), 8'h1);
        chk("push1_psr", 8'(psr), 8'h04);
        write_psr(5'b00011);
        irq_save = 1'b1;
        step();
        idle_inputs();
        chk("push2_depth", 8'(stk_depth), 8'h2);
        write_psr(5'b11111);
        rti_restore = 1'b1;
        step();
        chk("pop1_psr", 8'(psr), 8'h03);
        chk("pop1_depth", 8'(stk_depth), 8'h1);
        step();
        chk("pop2_psr", 8'(psr), 8'h04);
        chk("pop2_depth", 8'(stk_depth), 8'h0);
        step();
        idle_inputs();
        chk("unf_flag", 8'(stk_unf), 8'h1);
        chk("unf_psr", 8'(psr), 8'h04);
        chk("unf_depth", 8'(stk_depth), 8'h0);

        // Overflow: three pushes into a 2-deep stack
        write_psr(5'b00001);
        irq_save = 1'b1;
        step();
        idle_inputs();
        write_psr(5'b00010);
        irq_save = 1'b1;
        step();
        idle_inputs();
        chk("ovf_pre", 8'(stk_ovf), 8'h0);
        write_psr(5'b00011);
        irq_save = 1'b1;
        step();
        idle_inputs();
        chk("ovf_depth", 8'(stk_depth), 8'h2);
        chk("ovf_flag", 8'(stk_ovf), 8'h1);
        rti_restore = 1'b1;
        step();
        chk("ovf_pop1", 8'(psr), 8'h02);
        step();
        idle_inputs();
        chk("ovf_pop2", 8'(psr), 8'h01);
        chk("ovf_sticky", 8'(stk_ovf), 8'h1);
        chk("unf_sticky", 8'(stk_unf), 8'h1);

        // CMP setting Z in the same cycle as an EQ request
        write_psr(5'b00000);
        flags_en  = 1'b1;
        flags_sel = 5'b00100;
        flags_in  = 5'b00100;
        cond_req  = 1'b1;
        cond_code = 4'd0;
        step();
        flags_en = 1'b0;
        chk("byp_psr", 8'(psr), 8'h04);
        chk("byp_valid", 8'(br_valid), 8'h1);
`ifdef FLAG_BYPASS_EN
        chk("byp_taken", 8'(br_taken), 8'h1);
`else
        chk("byp_taken", 8'(br_taken), 8'h0);
`endif
        step();
        cond_req = 1'b0;
        chk("byp_next_taken", 8'(br_taken), 8'h1);

        // Stall freezes everything, request held across release
        stall     = 1'b1;
        cond_req  = 1'b1;
        cond_code = 4'd1;
        flags_en  = 1'b1;
        flags_sel = 5'b11111;
        flags_in  = 5'b11000;
        step();
        chk("stall_valid", 8'(br_valid), 8'h0);
        chk("stall_psr", 8'(psr), 8'h04);
        chk("stall_taken", 8'(br_taken), 8'h1);
        stall    = 1'b0;
        flags_en = 1'b0;
        step();
        chk("unstall_valid", 8'(br_valid), 8'h1);
        chk("unstall_taken", 8'(br_taken), 8'h0);
        cond_req = 1'b0;

        // Back-to-back codes on psr=01010 (F=1, L=1)
        write_psr(5'b01010);
        cond_req  = 1'b1;
        cond_code = 4'd10;
        step();
        chk("lo", 8'(br_taken), 8'h0);
        cond_code = 4'd11;
        step();
        chk("hs", 8'(br_taken), 8'h1);
        chk("b2b_valid", 8'(br_valid), 8'h1);
        cond_code = 4'd12;
        step();
        chk("lt", 8'(br_taken), 8'h1);
        cond_code = 4'd13;
        step();
        chk("ge", 8'(br_taken), 8'h0);
        cond_code = 4'd8;
        step();
        chk("fs", 8'(br_taken), 8'h1);
        cond_code = 4'd15;
        step();
        chk("nv", 8'(br_taken), 8'h0);
        cond_code = 4'd14;
        step();
        chk("uc", 8'(br_taken), 8'h1);
        cond_code = 4'd3;
        step();
        chk("cc", 8'(br_taken), 8'h1);
        cond_code = 4'd6;

        // Reset mid-cycle with a request pending
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_valid", 8'(br_valid), 8'h0);
        chk("midrst_psr", 8'(psr), 8'h14);
        step();
        chk("midrst_valid2", 8'(br_valid), 8'h0);
        chk("midrst_ovf", 8'(stk_ovf), 8'h0);
        chk("midrst_unf", 8'(stk_unf), 8'h0);
        idle_inputs();
        reset = 1'b0;
        step();
        chk("midrst_after", 8'(br_valid), 8'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
